// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-lookahead slice,
// processing one nibble per cycle, least significant nibble first.

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Every carry is a flat sum of products, with no ripple path between bits.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    // Handshake: start is sampled only when busy=0 (IDLE or DONE). An accepted
    // start captures a/b/cin; busy stays high for NIB cycles, then done pulses
    // for one cycle while sum/cout/ovf are valid. A start held high through
    // the done cycle begins the next add with no idle gap.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CW+1:0]    nib_idx;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_c;
    logic             last_nib;

    assign nib_idx  = {cnt_q, 2'b00};
    assign slice_a  = a_q[nib_idx +: 4];
    assign slice_b  = b_q[nib_idx +: 4];
    assign last_nib = (cnt_q == CW'(NIB - 1));

    cla4 u_cla4 (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[nib_idx +: 4] = slice_s;
                carry_d = slice_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_nib) begin
                    // Counter parks at 0 so a single-nibble build never leaves it.
                    cnt_d   = '0;
                    cout_d  = slice_c;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=16): directed corner cases
// plus random adds checked against a plain-arithmetic reference model.

module tb_cla_seq_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_bad;
    int done_cnt;

    // Expected results as {ovf, cout, sum}, pushed at accept, popped at done.
    logic [W+1:0] exp_q[$];

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv);
        logic [W:0] t;
        logic       o;
        t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        o = (av[W-1] == bv[W-1]) && (t[W-1] != av[W-1]);
        return {o, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".sum"},  sum,  e[W-1:0]);
        check({tag, ".cout"}, cout, e[W]);
        check({tag, ".ovf"},  ovf,  e[W+1]);
    endtask

    // ---------------- driver ----------------
    // One isolated add; operands are scrambled after acceptance to prove capture.
    task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv);
        logic [W+1:0] e;
        int d0;
        e = model(av, bv, cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < NIB; k++) begin
            check({tag, ".busy_run"}, busy, 1);
            check({tag, ".done_run"}, done, 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        check_result(tag, e);
        @(negedge clk);
        check({tag, ".pulse"}, done, 0);
        check({tag, ".hold"}, sum, e[W-1:0]);
        check({tag, ".ndone"}, done_cnt - d0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W+1:0] e;
        logic [W-1:0] ra, rb;
        logic         rc;
        int           d0;

        n_checks = 0; n_bad = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sum",  sum, 0);
        check("rst.cout", cout, 0);
        check("rst.ovf",  ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        run_add("basic",  16'h1234, 16'h4321, 1'b0);
        run_add("ripple", 16'hFFFF, 16'h0001, 1'b0);
        run_add("cinrip", 16'hFFFF, 16'h0000, 1'b1);
        run_add("posovf", 16'h7FFF, 16'h0001, 1'b0);
        run_add("negovf", 16'h8000, 16'h8000, 1'b0);

        // Async reset mid-run while the counter is at 2; cout/ovf still hold 1.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.busy", busy, 0);
        check("arst.done", done, 0);
        check("arst.sum",  sum, 0);
        check("arst.cout", cout, 0);
        check("arst.ovf",  ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        check("arst.nodone", done_cnt - d0, 0);
        run_add("postrst", 16'h0001, 16'h0002, 1'b0);

        // start pulsed during RUN must be ignored.
        @(negedge clk);
        d0 = done_cnt;
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_result("ignore", model(16'h0F0F, 16'h0101, 1'b0));
        repeat (3) @(negedge clk);
        check("ignore.ndone", done_cnt - d0, 1);

        // Back-to-back adds with start held high.
        @(negedge clk);
        d0 = done_cnt;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc; start = 1'b1;
        exp_q.push_back(model(ra, rb, rc));
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < NIB; k++) begin
                @(negedge clk);
                check("b2b.busy", busy, 1);
            end
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("b2b.qempty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_result("b2b", e);
            end
            if (n < 5) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                a = ra; b = rb; cin = rc;
                exp_q.push_back(model(ra, rb, rc));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b.idle", busy, 0);
        check("b2b.ndone", done_cnt - d0, 6);
        check("b2b.qleft", exp_q.size(), 0);

        for (int n = 0; n < 20; n++) begin
            run_add("rand", W'($urandom), W'($urandom), 1'($urandom));
        end
        run_add("zero", 16'h0000, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
